pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 114 +++++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with a saturating back-pressure counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             xfer_in, xfer_out;

    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign stall_cnt = stall_q;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // A full skid blocks upstream, so no transfer-in can coincide with skid_valid_q.
    assign in_ready = !skid_valid_q;

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            if (xfer_out) begin
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (valid_q) begin
            if (xfer_out) begin
                if (xfer_in) data_d  = in_data;
                else         valid_d = 1'b0;
            end else if (xfer_in) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end else if (xfer_in) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end
        if (flush) begin
            valid_d      = 1'b0;
            data_d       = data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = skid_data_q;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (xfer_in) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (xfer_out) begin
            valid_d = 1'b0;
        end
        // Flush drops valid only; the payload bits are left as they were.
        if (flush) begin
            valid_d = 1'b0;
            data_d  = data_q;
        end
    end
`endif

    always_comb begin
        stall_d = stall_q;
        if (valid_q && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios then random traffic,
// compared each cycle against a queue-based model of the stage.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       nRST;
    logic       flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, in_ready2, out_valid2;
    logic [7:0] out_data, out_data2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int compared = 0;
    int mismatched = 0;

    logic [7:0]  q[$];
    logic [7:0]  m_data;
    int unsigned m_stall, m_stall2;

    pipe_stage_reg #(.WIDTH(8), .CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt));

    pipe_stage_reg #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .stall_cnt(stall_cnt2));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit exp_ready();
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic model_reset();
        q.delete();
        m_data   = 8'h00;
        m_stall  = 0;
        m_stall2 = 0;
    endtask

    task automatic check_all();
        check("in_ready",   {31'b0, in_ready},   {31'b0, exp_ready()});
        check("out_valid",  {31'b0, out_valid},  {31'b0, q.size() > 0});
        check("out_data",   {24'b0, out_data},   {24'b0, m_data});
        check("stall_cnt",  {16'b0, stall_cnt},  m_stall);
        check("sat_ready",  {31'b0, in_ready2},  {31'b0, exp_ready()});
        check("sat_valid",  {31'b0, out_valid2}, {31'b0, q.size() > 0});
        check("sat_stall",  {30'b0, stall_cnt2}, m_stall2);
    endtask

    // Sample at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        bit xi, xo;
        @(negedge CLK);
        check_all();
        xi = in_valid && exp_ready();
        xo = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready) begin
            if (m_stall  < 32'hFFFF) m_stall++;
            if (m_stall2 < 3)        m_stall2++;
        end
        if (flush) q.delete();
        else begin
            if (xo) void'(q.pop_front());
            if (xi) q.push_back(in_data);
        end
        if (q.size() > 0) m_data = q[0];
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        #2;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data",  {24'b0, out_data},  32'd0);
        check("rst_stall", {16'b0, stall_cnt}, 32'd0);
        #10;
        nRST = 1'b1;
        #1;
        check("rel_ready", {31'b0, in_ready}, 32'd1);
        @(posedge CLK);
        #1;

        // Stream of four payloads at full throughput.
        drive(1'b1, 8'hA1, 1'b1, 1'b0);
        cycle();
        check("stream_first", {24'b0, out_data}, 32'hA1);
        for (int i = 2; i <= 4; i++) begin
            drive(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
            cycle();
            check("stream_seq", {24'b0, out_data}, 32'(8'hA0 + i));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        check("stream_stall", {16'b0, stall_cnt}, 32'd0);
        cycle();

        // Back-pressure: 0x55 held for five cycles while 0x66 is offered.
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h66, 1'b0, 1'b0);
            cycle();
            check("bp_hold", {24'b0, out_data}, 32'h55);
        end
        check("bp_stall", {16'b0, stall_cnt}, 32'd5);
        drive(1'b1, 8'h66, 1'b1, 1'b0);
        cycle();
        check("bp_second", {24'b0, out_data}, 32'h66);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        cycle();

        // Flush coinciding with a transfer-in of 0x77 while 0x55 is held.
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h77, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_ready", {31'b0, in_ready},  32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle();

        // Asynchronous reset with the stage full.
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        cycle();
        cycle();
        #2;
        nRST = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_data",  {24'b0, out_data},  32'd0);
        check("arst_stall", {16'b0, stall_cnt}, 32'd0);
        check("arst_sat",   {30'b0, stall_cnt2}, 32'd0);
        model_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge CLK);
        #1;
        nRST = 1'b1;
        #1;
        check("arst_ready", {31'b0, in_ready}, 32'd1);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) cycle();

        // Saturation on the two-bit counter, then flush must leave it alone.
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        cycle();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            cycle();
            check("sat_seq", {30'b0, stall_cnt2}, (i < 3) ? (i + 1) : 3);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        cycle();
        check("sat_flush", {30'b0, stall_cnt2}, 32'd3);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 19) == 0));
            cycle();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
